// File: rtl/prog_loader.sv
// Boot loader: parses A5/count/data[/checksum] frames into a 32x8 program memory while holding the CPU.
// Optional checksum byte and CHECK state are built when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_wr,
    output logic [4:0] mem_addr,
    output logic [7:0] mem_din,
    output logic       cpu_hold,
    output logic       done,
    output logic       err,
    output logic [1:0] dbg_state
);

    // Stream handshake: a byte transfers on every rising clk edge where in_valid && in_ready.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DATA  = 2'd2
`ifdef PROG_LOADER_CHECKSUM_EN
        , CHECK = 2'd3
`endif
    } state_t;

    state_t     state_q, state_d;
    logic       ready_q;
    logic [5:0] cnt_q, cnt_d;
    logic [4:0] idx_q, idx_d;
    logic [7:0] timer_q, timer_d;
    logic       wr_q, wr_d;
    logic [4:0] addr_q, addr_d;
    logic [7:0] din_q, din_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       hold_q, hold_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
`else
    logic       fin_q, fin_d;
`endif
    logic       accept;

    assign accept = in_valid && ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        done_d  = 1'b0;
        err_d   = err_q;
        hold_d  = hold_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`else
        fin_d   = 1'b0;
        // Completion lands one cycle after the last write; a header accepted meanwhile still wins hold.
        if (fin_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
            err_d  = 1'b0;
        end
`endif
        if (state_q == IDLE) timer_d = 8'd0;
        else                 timer_d = accept ? 8'd0 : timer_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (accept && in_data == 8'hA5) begin
                    state_d = COUNT;
                    hold_d  = 1'b1;
                end
            end
            COUNT: begin
                if (accept) begin
                    if (in_data != 8'd0 && in_data <= 8'd32) begin
                        cnt_d   = in_data[5:0];
                        idx_d   = 5'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_d   = 8'd0;
`endif
                        state_d = DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    wr_d   = 1'b1;
                    addr_d = idx_q;
                    din_d  = in_data;
                    idx_d  = idx_q + 5'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + in_data;
                    if ({1'b0, idx_q} == cnt_q - 6'd1) state_d = CHECK;
`else
                    if ({1'b0, idx_q} == cnt_q - 6'd1) begin
                        state_d = IDLE;
                        fin_d   = 1'b1;
                    end
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    if (in_data == sum_q) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                        err_d  = 1'b0;
                    end else begin
                        err_d  = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Timer value 255 means 255 idle cycles already elapsed; this is the 256th.
        if (state_q != IDLE && !accept && timer_q == 8'hFF) begin
            err_d   = 1'b1;
            state_d = IDLE;
            timer_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            cnt_q   <= 6'd0;
            idx_q   <= 5'd0;
            timer_q <= 8'd0;
            wr_q    <= 1'b0;
            addr_q  <= 5'd0;
            din_q   <= 8'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q   <= 8'd0;
`else
            fin_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`else
            fin_q   <= fin_d;
`endif
        end
    end

    assign in_ready  = ready_q;
    assign mem_wr    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_din   = din_q;
    assign cpu_hold  = hold_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule
